// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, bundle layouts, ALU opcodes and CCR bit indices.
package pipe_pkg;

    localparam int unsigned W        = 16;
    localparam int unsigned D_E_SIZE = 18 + 3 * W;
    localparam int unsigned E_M_SIZE = 8 + 3 * W;
    localparam int unsigned CCR_W    = 3;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned SH_W     = 4;

    // D_E bundle field offsets (LSB positions)
    localparam int unsigned DE_IMM_LSB   = 0;
    localparam int unsigned DE_SHAMT_LSB = W;
    localparam int unsigned DE_RDST_LSB  = W + 4;
    localparam int unsigned DE_RSRC_LSB  = 2 * W + 4;
    localparam int unsigned DE_WB_LSB    = 3 * W + 4;
    localparam int unsigned DE_EX_LSB    = 3 * W + 7;
    localparam int unsigned DE_MEM_LSB   = 3 * W + 13;

    // Bit positions inside the EX control field
    localparam int unsigned EX_EN     = 5;
    localparam int unsigned EX_OP_MSB = 4;
    localparam int unsigned EX_OP_LSB = 1;
    localparam int unsigned EX_SHSEL  = 0;

    localparam int unsigned CCR_Z = 0;
    localparam int unsigned CCR_N = 1;
    localparam int unsigned CCR_C = 2;

    localparam logic [OP_W-1:0] ALU_NOP  = 4'h0;
    localparam logic [OP_W-1:0] ALU_NOT  = 4'h1;
    localparam logic [OP_W-1:0] ALU_INC  = 4'h2;
    localparam logic [OP_W-1:0] ALU_DEC  = 4'h3;
    localparam logic [OP_W-1:0] ALU_ADD  = 4'h4;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'h5;
    localparam logic [OP_W-1:0] ALU_AND  = 4'h6;
    localparam logic [OP_W-1:0] ALU_OR   = 4'h7;
    localparam logic [OP_W-1:0] ALU_SHL  = 4'h8;
    localparam logic [OP_W-1:0] ALU_SHR  = 4'h9;
    localparam logic [OP_W-1:0] ALU_MOV  = 4'hA;
    localparam logic [OP_W-1:0] ALU_LDM  = 4'hB;
    localparam logic [OP_W-1:0] ALU_SETC = 4'hC;
    localparam logic [OP_W-1:0] ALU_CLRC = 4'hD;

    typedef struct packed {
        logic [4:0]    mem;
        logic [5:0]    ex;
        logic [2:0]    wb;
        logic [W-1:0]  rsrc;
        logic [W-1:0]  rdst;
        logic [SH_W-1:0] shamt;
        logic [W-1:0]  imm;
    } de_t;

    typedef struct packed {
        logic [4:0]    mem;
        logic [2:0]    wb;
        logic [W-1:0]  result;
        logic [W-1:0]  rsrc;
        logic [W-1:0]  imm;
    } em_t;

endpackage

// File: rtl/execute_stage_if.sv
// Execute-stage bus: D_E bundle and control in, E_M bundle and CCR out.
interface execute_stage_if;
    import pipe_pkg::*;

    logic [D_E_SIZE-1:0] data_in;
    logic                stall;
    logic                flush;
    logic [E_M_SIZE-1:0] data_out;
    logic [CCR_W-1:0]    ccr;

    modport master (output data_in, stall, flush, input data_out, ccr);
    modport slave  (input data_in, stall, flush, output data_out, ccr);
endinterface

// File: rtl/Register.sv
// Generic register with synchronous reset, synchronous clear and load enable.
module Register #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= d;
    end

endmodule

// File: rtl/alu16.sv
// Combinational ALU/shifter; flag_we marks which CCR bits the op updates.
module alu16 import pipe_pkg::*; (
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     imm,
    input  logic [OP_W-1:0]  op,
    input  logic [SH_W-1:0]  s,
    input  logic             c_in,
    output logic [W-1:0]     result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic [CCR_W-1:0] flag_we
);

    logic [W:0] wide;
    logic       nz_we;
    logic       c_we;

    always_comb begin
        wide   = '0;
        result = a;
        c      = c_in;
        nz_we  = 1'b0;
        c_we   = 1'b0;
        case (op)
            ALU_NOT: begin
                result = ~a;
                nz_we  = 1'b1;
            end
            ALU_INC: begin
                wide   = {1'b0, a} + (W+1)'(1);
                result = wide[W-1:0];
                c      = wide[W];
                nz_we  = 1'b1;
                c_we   = 1'b1;
            end
            ALU_DEC: begin
                // Bit W of the W+1-bit difference is the borrow (a == 0)
                wide   = {1'b0, a} - (W+1)'(1);
                result = wide[W-1:0];
                c      = wide[W];
                nz_we  = 1'b1;
                c_we   = 1'b1;
            end
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[W-1:0];
                c      = wide[W];
                nz_we  = 1'b1;
                c_we   = 1'b1;
            end
            ALU_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[W-1:0];
                c      = wide[W];
                nz_we  = 1'b1;
                c_we   = 1'b1;
            end
            ALU_AND: begin
                result = a & b;
                nz_we  = 1'b1;
            end
            ALU_OR: begin
                result = a | b;
                nz_we  = 1'b1;
            end
            ALU_SHL: begin
                nz_we = 1'b1;
                if (s != '0) begin
                    // Bit W catches a[W-s], the last bit shifted out
                    wide   = {1'b0, a} << s;
                    result = wide[W-1:0];
                    c      = wide[W];
                    c_we   = 1'b1;
                end
            end
            ALU_SHR: begin
                nz_we = 1'b1;
                if (s != '0) begin
                    // Bit 0 catches a[s-1], the last bit shifted out
                    wide   = {a, 1'b0} >> s;
                    result = wide[W:1];
                    c      = wide[0];
                    c_we   = 1'b1;
                end
            end
            ALU_MOV:  result = b;
            ALU_LDM:  result = imm;
            ALU_SETC: begin
                c    = 1'b1;
                c_we = 1'b1;
            end
            ALU_CLRC: begin
                c    = 1'b0;
                c_we = 1'b1;
            end
            default: result = a;
        endcase
    end

    assign z = (result == '0);
    assign n = result[W-1];

    always_comb begin
        flag_we        = '0;
        flag_we[CCR_Z] = nz_we;
        flag_we[CCR_N] = nz_we;
        flag_we[CCR_C] = c_we;
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU between the D_E slices and the E_M buffer, plus the CCR.
module execute_stage import pipe_pkg::*; (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);

    de_t              de;
    em_t              em_next;
    logic [OP_W-1:0]  op_eff;
    logic [SH_W-1:0]  shift_amt;
    logic [W-1:0]     alu_result;
    logic             alu_z;
    logic             alu_n;
    logic             alu_c;
    logic [CCR_W-1:0] flag_we;
    logic [CCR_W-1:0] flag_val;
    logic [CCR_W-1:0] ccr_next;

    assign de = de_t'(bus.data_in);

    // A disabled ALU behaves as NOP: result = Rdst, flags untouched
    assign op_eff    = de.ex[EX_EN] ? de.ex[EX_OP_MSB:EX_OP_LSB] : ALU_NOP;
    assign shift_amt = de.ex[EX_SHSEL] ? de.shamt : de.rsrc[SH_W-1:0];

    alu16 u_alu (
        .a       (de.rdst),
        .b       (de.rsrc),
        .imm     (de.imm),
        .op      (op_eff),
        .s       (shift_amt),
        .c_in    (bus.ccr[CCR_C]),
        .result  (alu_result),
        .z       (alu_z),
        .n       (alu_n),
        .c       (alu_c),
        .flag_we (flag_we)
    );

    always_comb begin
        flag_val        = '0;
        flag_val[CCR_Z] = alu_z;
        flag_val[CCR_N] = alu_n;
        flag_val[CCR_C] = alu_c;
        ccr_next        = bus.ccr;
        for (int i = 0; i < int'(CCR_W); i++) begin
            if (flag_we[i]) ccr_next[i] = flag_val[i];
        end
    end

    always_comb begin
        em_next        = '0;
        em_next.mem    = de.mem;
        em_next.wb     = de.wb;
        em_next.result = alu_result;
        em_next.rsrc   = de.rsrc;
        em_next.imm    = de.imm;
    end

    Register #(.WIDTH(E_M_SIZE)) u_em_reg (
        .clk (clk),
        .rst (rst),
        .en  (~bus.stall),
        .clr (bus.flush),
        .d   (em_next),
        .q   (bus.data_out)
    );

    // Flush inserts a bubble but must not disturb the flags
    Register #(.WIDTH(CCR_W)) u_ccr_reg (
        .clk (clk),
        .rst (rst),
        .en  (~bus.stall & ~bus.flush),
        .clr (1'b0),
        .d   (ccr_next),
        .q   (bus.ccr)
    );

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage pipeline. Consumes the registered decode-to-execute bundle, performs the ALU/shift operation, and maintains the condition-code register (CCR). Registers the result and pass-through control into the execute-to-memory buffer for the memory stage. Supports pipeline stall (hold) and flush (bubble insertion).

## Interface

Parameters:
- W, 16, datapath width
- D_E_SIZE, 18+3*W, input bundle width
- E_M_SIZE, 8+3*W, output bundle width

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- data_in  input  D_E_SIZE  {MEM[4:0], EX[5:0], WB[2:0], Rsrc[W-1:0], Rdst[W-1:0], shamt[3:0], imm[W-1:0]}, MSB first
- stall  input  1  hold the E_M buffer and CCR
- flush  input  1  load a bubble into the E_M buffer
- data_out  output  E_M_SIZE  {MEM[4:0], WB[2:0], result[W-1:0], Rsrc[W-1:0], imm[W-1:0]}, MSB first
- ccr  output  3  {C, N, Z} flags, registered

## Operation

EX field:
- EX[5] = alu_en
- EX[4:1] = alu_op
- EX[0] = sham_sel (1: shift amount = shamt; 0: Rsrc[3:0])

Operand A is Rdst and operand B is Rsrc. When alu_en = 0, result = Rdst and the flags are untouched.

alu_op behaviour:
- 0 NOP: result = A
- 1 NOT: result = ~A
- 2 INC: result = A+1
- 3 DEC: result = A-1
- 4 ADD: result = A+B
- 5 SUB: result = A-B
- 6 AND: result = A&B
- 7 OR: result = A|B
- 8 SHL: result = A<<s
- 9 SHR: logical, result = A>>s
- A MOV: result = B
- B LDM: result = imm
- C SETC: result = A, C set to 1
- D CLRC: result = A, C cleared to 0
- E–F: treated as NOP

Width and flag rules:
- Arithmetic is computed at W+1 bits. C is bit W for ADD/INC; C is the borrow (A<B, or A==0 for DEC) for SUB/DEC.
- SHL: C = A[W-s]. SHR: C = A[s-1]. For s = 0, result = A and C is unchanged.
- Z = (result==0) and N = result[W-1]. Both update for ops 1–9 only. NOT, AND and OR leave C unchanged.
- MOV, LDM and NOP never touch the flags.

Pass-through: MEM, WB, Rsrc (store data) and imm travel unchanged into the E_M buffer.

Update priority each edge:
- rst: data_out = 0, ccr = 0.
- Else flush: data_out = 0 (MEM = 0, WB = 0 makes a no-write bubble), ccr holds.
- Else stall: data_out and ccr hold.
- Else: data_out and ccr load new values.

## Timing

- Latency: 1 cycle. The bundle present before edge k appears on data_out after edge k. The ccr update is visible in the same cycle.
- Both outputs are 0 after any reset edge, including mid-stream. There is no partial state.
- Flush and stall asserted together: flush wins.
- Back-to-back dependent ops: the flags used are the registered ccr. There is no internal forwarding; forwarding is a separate block.
- Stall held N cycles: data_out is stable for N cycles, and the instruction at data_in is consumed on the first non-stalled edge.
- Pure register-to-register path: the combinational ALU sits between the data_in slices and the E_M flops.

## Structure

- Shared package pipe_pkg holds:
  - W
  - D_E_SIZE and E_M_SIZE
  - field offsets for MEM/EX/WB
  - alu_op localparams (ALU_NOP … ALU_CLRC)
  - CCR bit indices (Z=0, N=1, C=2)
- Sub-module alu16: combinational, takes (a, b, imm, op, s, c_in) and returns (result, z, n, c, flag_we).
- The top level holds only the E_M register and the CCR register, built with the existing generic Register module.

## Test plan

- Reset: drive rst for 2 edges with random data_in -> data_out = 0, ccr = 000. Release rst -> the first instruction appears 1 cycle later.
- ADD overflow: Rdst=FFFF, Rsrc=0001, alu_op=4, en=1 -> result 0000, ccr {C,N,Z} = 101. Next SUB Rdst=0003, Rsrc=0005 -> result FFFE, ccr = 110.
- Shifts: SHL Rdst=8001, shamt=1, sham_sel=1 -> result 0002, C=1. SHR Rdst=0001, Rsrc=0001, sham_sel=0 -> result 0000, C=1, Z=1. Shift by 0 -> C unchanged.
- Stall/flush: stall 3 cycles during an ADD -> data_out and ccr frozen. Stall and flush together -> data_out = 0 next cycle, ccr unchanged.
- Pass-through: MEM=10101, WB=101, Rsrc=1234, imm=BEEF, en=0, Rdst=5555 -> data_out fields match exactly, result = 5555, ccr unchanged.
